// File: rtl/pe_flow_sequencer_if.sv
// Scratch-pad side of the PE flow sequencer: input/weight/psum handshakes plus per-beat indices.
// master = sequencer (drives acks, Psum_rdy, indices); slave = scratch-pads.
interface pe_flow_sequencer_if #(
  parameter int PCH_W = 4,
  parameter int R_W   = 4,
  parameter int PM_W  = 4,
  parameter int TW_W  = 6,
  parameter int ROW_W = 9
);
  logic             Input_rdy;
  logic             Input_ack;
  logic             Weight_rdy;
  logic             Weight_ack;
  logic             Psum_rdy;
  logic             Psum_ack;
  logic [ROW_W-1:0] o_in_pix;
  logic [PCH_W-1:0] o_in_ch;
  logic [PCH_W-1:0] o_wt_ch;
  logic [R_W-1:0]   o_wt_r;
  logic [PM_W-1:0]  o_wt_m;
  logic [TW_W-1:0]  o_ps_t;
  logic [PCH_W-1:0] o_ps_ch;
  logic [R_W-1:0]   o_ps_r;
  logic [PM_W-1:0]  o_ps_m;
  logic [ROW_W-1:0] o_in_px;

  modport master (
    input  Input_rdy, Weight_rdy, Psum_ack,
    output Input_ack, Weight_ack, Psum_rdy,
    output o_in_pix, o_in_ch, o_wt_ch, o_wt_r, o_wt_m,
    output o_ps_t, o_ps_ch, o_ps_r, o_ps_m, o_in_px
  );

  modport slave (
    output Input_rdy, Weight_rdy, Psum_ack,
    input  Input_ack, Weight_ack, Psum_rdy,
    input  o_in_pix, o_in_ch, o_wt_ch, o_wt_r, o_wt_m,
    input  o_ps_t, o_ps_ch, o_ps_r, o_ps_m, o_in_px
  );
endinterface

// File: rtl/pe_flow_sequencer.sv
// PE flow sequencer: nested-loop indices and dependency-gated handshakes for input/weight/psum streams.
// Zero-latency indices from registered counters; i_stall gates all handshakes; PE_SEQ_PREFETCH_EN widens the input window by U.
module pe_flow_sequencer #(
  parameter int PCH_W = 4,
  parameter int R_W   = 4,
  parameter int PM_W  = 4,
  parameter int TW_W  = 6,
  parameter int U_W   = 2,
  parameter int ROW_W = 9
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic             i_stall,
  input  logic [PCH_W-1:0] i_pch,
  input  logic [R_W-1:0]   i_r,
  input  logic [PM_W-1:0]  i_pm,
  input  logic [TW_W-1:0]  i_tw,
  input  logic [U_W-1:0]   i_u,
  pe_flow_sequencer_if.master bus,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WORK, S_STALL} state_t;

  state_t state_q, state_nxt;

  logic [PCH_W-1:0] pch_q;
  logic [R_W-1:0]   r_q;
  logic [PM_W-1:0]  pm_q;
  logic [TW_W-1:0]  tw_q;
  logic [U_W-1:0]   u_q;
  logic [ROW_W-1:0] npix_q;

  logic [ROW_W-1:0] in_pix;
  logic [PCH_W-1:0] in_ch;
  logic             in_done;
  logic [PCH_W-1:0] wt_ch;
  logic [R_W-1:0]   wt_r;
  logic [PM_W-1:0]  wt_m;
  logic             wt_done;
  logic [TW_W-1:0]  ps_t;
  logic [PCH_W-1:0] ps_ch;
  logic [R_W-1:0]   ps_r;
  logic [PM_W-1:0]  ps_m;
  logic             ps_done;

  logic             run, clr;
  logic             in_xfer, wt_xfer, ps_xfer;
  logic             in_ok, wt_ok;
  logic [ROW_W-1:0] px_base, px, win_end;

  logic in_ch_last, in_pix_last;
  logic wt_ch_last, wt_r_last, wt_m_last;
  logic ps_t_last, ps_ch_last, ps_r_last, ps_m_last;

  // FSM
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    o_done    = 1'b0;
    case (state_q)
      S_IDLE:  if (i_start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = i_abort ? S_IDLE : S_WORK;
      S_WORK: begin
        if (i_abort)      state_nxt = S_IDLE;
        else if (i_stall) state_nxt = S_STALL;
        else if (ps_done) begin
          state_nxt = S_IDLE;
          o_done    = 1'b1;
        end
      end
      S_STALL: begin
        if (i_abort)       state_nxt = S_IDLE;
        else if (!i_stall) state_nxt = S_WORK;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (state_q != S_IDLE);
  assign clr    = (state_nxt == S_IDLE);

  // Config is captured on start; NPIX is derived one cycle later in LOAD.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pch_q  <= '0;
      r_q    <= '0;
      pm_q   <= '0;
      tw_q   <= '0;
      u_q    <= '0;
      npix_q <= '0;
    end else if (state_q == S_IDLE && i_start) begin
      pch_q <= i_pch;
      r_q   <= i_r;
      pm_q  <= i_pm;
      tw_q  <= i_tw;
      u_q   <= i_u;
    end else if (state_q == S_LOAD) begin
      npix_q <= (ROW_W'(tw_q) - ROW_W'(1)) * ROW_W'(u_q) + ROW_W'(r_q);
    end
  end

  assign px_base = ROW_W'(ps_t) * ROW_W'(u_q);
  assign px      = px_base + ROW_W'(ps_r);
`ifdef PE_SEQ_PREFETCH_EN
  assign win_end = px_base + ROW_W'(r_q) - ROW_W'(1) + ROW_W'(u_q);
`else
  assign win_end = px_base + ROW_W'(r_q) - ROW_W'(1);
`endif

  assign in_ch_last  = (in_ch == pch_q - PCH_W'(1));
  assign in_pix_last = (in_pix == npix_q - ROW_W'(1));
  assign wt_ch_last  = (wt_ch == pch_q - PCH_W'(1));
  assign wt_r_last   = (wt_r == r_q - R_W'(1));
  assign wt_m_last   = (wt_m == pm_q - PM_W'(1));
  assign ps_t_last   = (ps_t == tw_q - TW_W'(1));
  assign ps_ch_last  = (ps_ch == pch_q - PCH_W'(1));
  assign ps_r_last   = (ps_r == r_q - R_W'(1));
  assign ps_m_last   = (ps_m == pm_q - PM_W'(1));

  // Lexicographic "strictly past" compares stand in for linear counter compares.
  assign in_ok = in_done || (in_pix > px) || (in_pix == px && in_ch > ps_ch);
  assign wt_ok = wt_done || (wt_ch > ps_ch) ||
                 (wt_ch == ps_ch && (wt_r > ps_r || (wt_r == ps_r && wt_m > ps_m)));

  assign run = (state_q == S_WORK) && !i_stall && !i_abort;

  assign bus.Input_ack  = run && !in_done && (in_pix <= win_end);
  assign bus.Weight_ack = run && !wt_done;
  assign bus.Psum_rdy   = run && !ps_done && wt_ok && in_ok;

  assign in_xfer = bus.Input_rdy && bus.Input_ack;
  assign wt_xfer = bus.Weight_rdy && bus.Weight_ack;
  assign ps_xfer = bus.Psum_rdy && bus.Psum_ack;

  // Loop counters; each holds its final indices once done.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || clr) begin
      in_pix  <= '0;
      in_ch   <= '0;
      in_done <= 1'b0;
      wt_ch   <= '0;
      wt_r    <= '0;
      wt_m    <= '0;
      wt_done <= 1'b0;
      ps_t    <= '0;
      ps_ch   <= '0;
      ps_r    <= '0;
      ps_m    <= '0;
      ps_done <= 1'b0;
    end else begin
      if (in_xfer) begin
        if (in_ch_last && in_pix_last) in_done <= 1'b1;
        else if (!in_ch_last)          in_ch <= in_ch + PCH_W'(1);
        else begin
          in_ch  <= '0;
          in_pix <= in_pix + ROW_W'(1);
        end
      end
      if (wt_xfer) begin
        if (wt_m_last && wt_r_last && wt_ch_last) wt_done <= 1'b1;
        else if (!wt_m_last) wt_m <= wt_m + PM_W'(1);
        else begin
          wt_m <= '0;
          if (!wt_r_last) wt_r <= wt_r + R_W'(1);
          else begin
            wt_r  <= '0;
            wt_ch <= wt_ch + PCH_W'(1);
          end
        end
      end
      if (ps_xfer) begin
        if (ps_m_last && ps_r_last && ps_ch_last && ps_t_last) ps_done <= 1'b1;
        else if (!ps_m_last) ps_m <= ps_m + PM_W'(1);
        else begin
          ps_m <= '0;
          if (!ps_r_last) ps_r <= ps_r + R_W'(1);
          else begin
            ps_r <= '0;
            if (!ps_ch_last) ps_ch <= ps_ch + PCH_W'(1);
            else begin
              ps_ch <= '0;
              ps_t  <= ps_t + TW_W'(1);
            end
          end
        end
      end
    end
  end

  assign bus.o_in_pix = in_pix;
  assign bus.o_in_ch  = in_ch;
  assign bus.o_wt_ch  = wt_ch;
  assign bus.o_wt_r   = wt_r;
  assign bus.o_wt_m   = wt_m;
  assign bus.o_ps_t   = ps_t;
  assign bus.o_ps_ch  = ps_ch;
  assign bus.o_ps_r   = ps_r;
  assign bus.o_ps_m   = ps_m;
  assign bus.o_in_px  = px;

endmodule

// File: tb/tb_pe_flow_sequencer.sv
// Directed bench for pe_flow_sequencer; honours PE_SEQ_PREFETCH_EN for the input-window expectations.
module tb_pe_flow_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, start, abort, stall, busy, done;
  logic [3:0] pch, r, pm;
  logic [5:0] tw;
  logic [1:0] u;

  always #5 clk = ~clk;

  pe_flow_sequencer_if bus_if ();

  pe_flow_sequencer dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_abort (abort),
    .i_stall (stall),
    .i_pch   (pch),
    .i_r     (r),
    .i_pm    (pm),
    .i_tw    (tw),
    .i_u     (u),
    .bus     (bus_if),
    .o_busy  (busy),
    .o_done  (done)
  );

  int n_chk = 0, n_pass = 0;
  int n_in, n_wt, n_ps, n_done, seq_err, dep_err, win_err;
  int c_pch, c_r, c_pm, c_tw, c_u;
  bit rnd = 1'b0, ir = 1'b0, wr = 1'b0, pa = 1'b0;

  // One cycle: drive rdy/ack, observe the handshakes about to be registered, advance to next negedge.
  task automatic step();
    int k, t, ch, rr, m, tc, lim;
    bit px, wx, sx;
    if (rnd) begin
      bus_if.Input_rdy  = 1'($urandom_range(0, 1));
      bus_if.Weight_rdy = 1'($urandom_range(0, 1));
      bus_if.Psum_ack   = 1'($urandom_range(0, 1));
    end else begin
      bus_if.Input_rdy  = ir;
      bus_if.Weight_rdy = wr;
      bus_if.Psum_ack   = pa;
    end
    #1;
    sx = bus_if.Psum_rdy && bus_if.Psum_ack;
    px = bus_if.Input_rdy && bus_if.Input_ack;
    wx = bus_if.Weight_rdy && bus_if.Weight_ack;
    if (sx) begin
      k  = n_ps;
      m  = k % c_pm;
      rr = (k / c_pm) % c_r;
      ch = (k / (c_pm * c_r)) % c_pch;
      t  = k / (c_pm * c_r * c_pch);
      if (int'(bus_if.o_ps_t) != t || int'(bus_if.o_ps_ch) != ch || int'(bus_if.o_ps_r) != rr ||
          int'(bus_if.o_ps_m) != m || int'(bus_if.o_in_px) != t * c_u + rr) seq_err++;
      if ((t * c_u + rr) * c_pch + ch >= n_in) dep_err++;
      if ((ch * c_r + rr) * c_pm + m >= n_wt) dep_err++;
    end
    if (px) begin
      k  = n_in;
      if (int'(bus_if.o_in_pix) != k / c_pch || int'(bus_if.o_in_ch) != k % c_pch) seq_err++;
      tc = n_ps / (c_pm * c_r * c_pch);
      if (tc > c_tw - 1) tc = c_tw - 1;
`ifdef PE_SEQ_PREFETCH_EN
      lim = tc * c_u + c_r - 1 + c_u;
`else
      lim = tc * c_u + c_r - 1;
`endif
      if (k / c_pch > lim) win_err++;
    end
    if (wx) begin
      k  = n_wt;
      m  = k % c_pm;
      rr = (k / c_pm) % c_r;
      ch = k / (c_pm * c_r);
      if (int'(bus_if.o_wt_ch) != ch || int'(bus_if.o_wt_r) != rr || int'(bus_if.o_wt_m) != m) seq_err++;
    end
    if (sx) n_ps++;
    if (px) n_in++;
    if (wx) n_wt++;
    if (done) n_done++;
    @(negedge clk);
  endtask

  task automatic start_run(input int a_pch, input int a_r, input int a_pm, input int a_tw, input int a_u);
    c_pch = a_pch; c_r = a_r; c_pm = a_pm; c_tw = a_tw; c_u = a_u;
    pch = 4'(a_pch); r = 4'(a_r); pm = 4'(a_pm); tw = 6'(a_tw); u = 2'(a_u);
    n_in = 0; n_wt = 0; n_ps = 0; n_done = 0; seq_err = 0; dep_err = 0; win_err = 0;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_done(input int budget);
    for (int i = 0; i < budget && n_done == 0; i++) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ir = 1'b1; wr = 1'b1; pa = 1'b1; rnd = 1'b0;
    c_pch = 1; c_r = 1; c_pm = 1; c_tw = 1; c_u = 1;
    step(); step();
    n_chk++;
    if ({busy, done, bus_if.Input_ack, bus_if.Weight_ack, bus_if.Psum_rdy} !== 5'b0)
      $display("FAIL reset_ctl got=%b exp=00000", {busy, done, bus_if.Input_ack, bus_if.Weight_ack, bus_if.Psum_rdy});
    else n_pass++;
    n_chk++;
    if ({bus_if.o_in_pix, bus_if.o_in_ch, bus_if.o_wt_ch, bus_if.o_wt_r, bus_if.o_wt_m, bus_if.o_ps_t,
         bus_if.o_ps_ch, bus_if.o_ps_r, bus_if.o_ps_m, bus_if.o_in_px} !== '0)
      $display("FAIL reset_idx got=nonzero exp=0");
    else n_pass++;
    rst_n = 1'b1;
    step(); step();
    n_chk++;
    if ({busy, bus_if.Input_ack, bus_if.Weight_ack, bus_if.Psum_rdy} !== 4'b0)
      $display("FAIL idle_ctl got=%b exp=0000", {busy, bus_if.Input_ack, bus_if.Weight_ack, bus_if.Psum_rdy});
    else n_pass++;
  endtask

  task automatic test_single();
    int cyc;
    ir = 1'b1; wr = 1'b1; pa = 1'b1; rnd = 1'b0;
    start_run(1, 1, 1, 1, 1);
    cyc = 0;
    while (n_done == 0 && cyc < 20) begin
      step();
      cyc++;
    end
    n_chk++;
    if (n_done != 1 || cyc > 4) $display("FAIL single_latency got=%0d cycles done=%0d exp<=4 done=1", cyc, n_done);
    else n_pass++;
    n_chk++;
    if (n_in != 1 || n_wt != 1 || n_ps != 1)
      $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/1", n_in, n_wt, n_ps);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0 || bus_if.o_ps_t !== '0 || bus_if.o_in_pix !== '0)
      $display("FAIL single_idle got=busy%b done%b exp=busy0 done0 idx0", busy, done);
    else n_pass++;
  endtask

  task automatic test_random();
    rnd = 1'b1;
    start_run(2, 3, 2, 4, 1);
    run_done(3000);
    n_chk++;
    if (n_in != 12 || n_wt != 12 || n_ps != 48 || n_done != 1)
      $display("FAIL random_counts got=%0d/%0d/%0d done=%0d exp=12/12/48 done=1", n_in, n_wt, n_ps, n_done);
    else n_pass++;
    n_chk++;
    if (seq_err != 0) $display("FAIL random_order got=%0d exp=0", seq_err);
    else n_pass++;
    n_chk++;
    if (dep_err != 0 || win_err != 0) $display("FAIL random_deps got=%0d/%0d exp=0/0", dep_err, win_err);
    else n_pass++;
    rnd = 1'b0;
  endtask

  task automatic test_window();
    int exp_in;
`ifdef PE_SEQ_PREFETCH_EN
    exp_in = 5;
`else
    exp_in = 3;
`endif
    ir = 1'b1; wr = 1'b1; pa = 1'b0; rnd = 1'b0;
    start_run(1, 3, 1, 2, 2);
    repeat (30) step();
    n_chk++;
    if (n_in != exp_in) $display("FAIL window_inputs got=%0d exp=%0d", n_in, exp_in);
    else n_pass++;
    n_chk++;
    if (int'(bus_if.o_in_pix) != ((exp_in == 5) ? 4 : 3))
      $display("FAIL window_pix got=%0d exp=%0d", bus_if.o_in_pix, (exp_in == 5) ? 4 : 3);
    else n_pass++;
    n_chk++;
    if (bus_if.Psum_rdy !== 1'b1 || n_ps != 0 || bus_if.o_ps_m !== '0)
      $display("FAIL window_psum_hold got=rdy%b n%0d exp=rdy1 n0", bus_if.Psum_rdy, n_ps);
    else n_pass++;
    n_chk++;
    if (win_err != 0 || seq_err != 0) $display("FAIL window_order got=%0d/%0d exp=0/0", win_err, seq_err);
    else n_pass++;
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || n_done != 0) $display("FAIL window_abort got=busy%b done%0d exp=busy0 done0", busy, n_done);
    else n_pass++;
    pa = 1'b1;
  endtask

  task automatic test_stall();
    int b_in, b_wt, b_ps, k;
    ir = 1'b1; wr = 1'b1; pa = 1'b1; rnd = 1'b0;
    start_run(2, 3, 2, 4, 1);
    for (int i = 0; i < 300 && n_ps < 10; i++) step();
    b_in = n_in; b_wt = n_wt; b_ps = n_ps;
    stall = 1'b1;
    repeat (5) step();
    n_chk++;
    if (n_in != b_in || n_wt != b_wt || n_ps != b_ps || busy !== 1'b1)
      $display("FAIL stall_freeze got=%0d/%0d/%0d exp=%0d/%0d/%0d", n_in, n_wt, n_ps, b_in, b_wt, b_ps);
    else n_pass++;
    stall = 1'b0;
    #1;
    k = n_ps;
    n_chk++;
    if (int'(bus_if.o_ps_m) != k % 2 || int'(bus_if.o_ps_r) != (k / 2) % 3 ||
        int'(bus_if.o_ps_ch) != (k / 6) % 2 || int'(bus_if.o_ps_t) != k / 12)
      $display("FAIL stall_ps_idx got=%0d,%0d,%0d,%0d exp=%0d,%0d,%0d,%0d", bus_if.o_ps_t, bus_if.o_ps_ch,
               bus_if.o_ps_r, bus_if.o_ps_m, k / 12, (k / 6) % 2, (k / 2) % 3, k % 2);
    else n_pass++;
    n_chk++;
    if ((n_in < 12) ? (int'(bus_if.o_in_pix) != n_in / 2 || int'(bus_if.o_in_ch) != n_in % 2)
                    : (int'(bus_if.o_in_pix) != 5 || int'(bus_if.o_in_ch) != 1))
      $display("FAIL stall_in_idx got=%0d,%0d exp_count=%0d", bus_if.o_in_pix, bus_if.o_in_ch, n_in);
    else n_pass++;
    n_chk++;
    if (n_wt == 12 && (int'(bus_if.o_wt_ch) != 1 || int'(bus_if.o_wt_r) != 2 || int'(bus_if.o_wt_m) != 1))
      $display("FAIL stall_wt_idx got=%0d,%0d,%0d exp=1,2,1", bus_if.o_wt_ch, bus_if.o_wt_r, bus_if.o_wt_m);
    else n_pass++;
    @(negedge clk);
    run_done(500);
    n_chk++;
    if (n_in != 12 || n_wt != 12 || n_ps != 48 || n_done != 1 || seq_err != 0 || dep_err != 0 || win_err != 0)
      $display("FAIL stall_final got=%0d/%0d/%0d done=%0d err=%0d exp=12/12/48 done=1 err=0",
               n_in, n_wt, n_ps, n_done, seq_err + dep_err + win_err);
    else n_pass++;
  endtask

  task automatic test_abort();
    ir = 1'b1; wr = 1'b1; pa = 1'b1; rnd = 1'b0;
    start_run(2, 3, 2, 4, 1);
    for (int i = 0; i < 300 && n_ps < 10; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_chk++;
    if (n_ps != 10) $display("FAIL abort_no_advance got=%0d exp=10", n_ps);
    else n_pass++;
    n_chk++;
    if (busy !== 1'b0 || n_done != 0) $display("FAIL abort_idle got=busy%b done%0d exp=busy0 done0", busy, n_done);
    else n_pass++;
    n_chk++;
    if ({bus_if.o_in_pix, bus_if.o_in_ch, bus_if.o_wt_ch, bus_if.o_wt_r, bus_if.o_wt_m, bus_if.o_ps_t,
         bus_if.o_ps_ch, bus_if.o_ps_r, bus_if.o_ps_m, bus_if.o_in_px} !== '0)
      $display("FAIL abort_idx got=nonzero exp=0");
    else n_pass++;
    start_run(2, 3, 2, 4, 1);
    run_done(500);
    n_chk++;
    if (n_ps != 48 || n_done != 1 || seq_err != 0 || dep_err != 0)
      $display("FAIL abort_rerun got=%0d done=%0d err=%0d exp=48 done=1 err=0", n_ps, n_done, seq_err + dep_err);
    else n_pass++;
  endtask

  task automatic test_config_change();
    rnd = 1'b1;
    start_run(2, 3, 2, 4, 1);
    repeat (4) step();
    pm = 4'd1;
    tw = 6'd1;
    run_done(3000);
    n_chk++;
    if (n_ps != 48 || n_wt != 12 || n_done != 1)
      $display("FAIL cfg_latched got=%0d/%0d done=%0d exp=48/12 done=1", n_ps, n_wt, n_done);
    else n_pass++;
    n_chk++;
    if (seq_err != 0 || dep_err != 0) $display("FAIL cfg_order got=%0d exp=0", seq_err + dep_err);
    else n_pass++;
    rnd = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    pch = '0; r = '0; pm = '0; tw = '0; u = '0;
    bus_if.Input_rdy = 1'b0; bus_if.Weight_rdy = 1'b0; bus_if.Psum_ack = 1'b0;
    n_in = 0; n_wt = 0; n_ps = 0; n_done = 0; seq_err = 0; dep_err = 0; win_err = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_random();
    test_window();
    test_stall();
    test_abort();
    test_config_change();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
